// File: rtl/ks_sub_pkg.sv
// rtl/ks_sub_pkg.sv - shared constants, FSM state type and overflow helper for the serial subtractor
package ks_sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed overflow of a - b: operands differ in sign and the result sign departs from a.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/ks_sub_slice.sv
// rtl/ks_sub_slice.sv - combinational 4-bit Kogge-Stone prefix adder with carry-in
module ks_sub_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g, p;
  logic [3:0] g1, p1;
  logic [3:0] g2;

  // Prefix tree: carry-in folded into bit 0 generate, then distance-1 and distance-2 combine.
  always_comb begin
    g = x & y;
    p = x ^ y;

    g1[0] = g[0] | (p[0] & cin);
    p1[0] = p[0];
    g1[1] = g[1] | (p[1] & g1[0]);
    p1[1] = p[1] & p[0];
    g1[2] = g[2] | (p[2] & g[1]);
    p1[2] = p[2] & p[1];
    g1[3] = g[3] | (p[3] & g[2]);
    p1[3] = p[3] & p[2];

    g2[0] = g1[0];
    g2[1] = g1[1];
    g2[2] = g1[2] | (p1[2] & g1[0]);
    g2[3] = g1[3] | (p1[3] & g1[1]);

    s[0] = p[0] ^ cin;
    s[1] = p[1] ^ g2[0];
    s[2] = p[2] ^ g2[1];
    s[3] = p[3] ^ g2[2];
    cout = g2[3];
  end

endmodule

// File: rtl/ks_serial_subtractor.sv
// rtl/ks_serial_subtractor.sv - nibble-serial a - b using one Kogge-Stone slice per cycle
module ks_serial_subtractor
  import ks_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   nb_q, nb_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] x_nib, y_nib, s_nib;
  logic               slice_cout;

  // Pick the operand nibbles addressed by the slice counter.
  always_comb begin
    x_nib = '0;
    y_nib = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        x_nib = a_q[k*SLICE_W +: SLICE_W];
        y_nib = nb_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  ks_sub_slice u_slice (
    .x    (x_nib),
    .y    (y_nib),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (slice_cout)
  );

  // Next-state logic: accept in IDLE, one slice per RUN cycle, publish the result on leaving RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    nb_d     = nb_q;
    work_d   = work_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            work_d[k*SLICE_W +: SLICE_W] = s_nib;
          end
        end
        carry_d = slice_cout;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d  = DONE;
          diff_d   = work_d;
          borrow_d = ~slice_cout;
          ovf_d    = sub_overflow(a_q[WIDTH-1], ~nb_q[WIDTH-1], work_d[WIDTH-1]);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      nb_q     <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ks_serial_subtractor.sv
// tb/tb_ks_serial_subtractor.sv - scoreboard testbench for the nibble-serial subtractor
module tb_ks_serial_subtractor;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic prev_ov = 1'b0;
  exp_t exp_q[$];

  ks_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands until accepted; optionally push the expected result.
  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic push, input exp_t e);
    int bound;
    in_valid = 1'b1;
    a = va;
    b = vb;
    bound = 0;
    while (!in_ready && bound < 100) begin
      @(posedge clk); #1;
      bound++;
    end
    check("accept_timeout", {31'd0, in_ready}, 32'd1);
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int bound;
    bound = 0;
    while ((exp_q.size() != 0 || out_valid) && bound < 200) begin
      @(posedge clk); #1;
      bound++;
    end
    check("drain_timeout", bound < 200 ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Monitor: latency on each rising out_valid, pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_ov) check("latency", cyc - accept_cyc, LAT);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("diff", {16'd0, diff}, {16'd0, e.diff});
          check("borrow_out", {31'd0, borrow_out}, {31'd0, e.borrow});
          check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        end
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   bound;

    // Reset for three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {16'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow_out}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: basic, borrow, equal operands, signed overflow.
    e = '{diff: 16'h1000, borrow: 1'b0, ovf: 1'b0}; send(16'h1234, 16'h0234, 1'b1, e); drain();
    e = '{diff: 16'hFFFF, borrow: 1'b1, ovf: 1'b0}; send(16'h0000, 16'h0001, 1'b1, e); drain();
    e = '{diff: 16'h0000, borrow: 1'b0, ovf: 1'b0}; send(16'h1234, 16'h1234, 1'b1, e); drain();
    e = '{diff: 16'h7FFF, borrow: 1'b0, ovf: 1'b1}; send(16'h8000, 16'h0001, 1'b1, e); drain();

    // Backpressure: stall the result while new operands are offered.
    out_ready = 1'b0;
    e = '{diff: 16'hF1FF, borrow: 1'b1, ovf: 1'b0}; send(16'h00FF, 16'h0F00, 1'b1, e);
    bound = 0;
    while (!out_valid && bound < 50) begin
      @(posedge clk); #1;
      bound++;
    end
    check("stall_reach_done", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_diff", {16'd0, diff}, 32'h0000F1FF);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    e = '{diff: 16'hFFFE, borrow: 1'b0, ovf: 1'b0}; send(16'hFFFF, 16'h0001, 1'b1, e); drain();

    // Reset two RUN cycles into an operation: nothing must come out.
    send(16'h5555, 16'h1111, 1'b0, e);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_diff", {16'd0, diff}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    e = '{diff: 16'h4444, borrow: 1'b0, ovf: 1'b0}; send(16'h5555, 16'h1111, 1'b1, e); drain();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_serial_subtractor.md
# ks_serial_subtractor

Nibble-serial two's-complement subtractor, the inverse-direction companion to the 4-bit Kogge-Stone adder. It computes `a - b` on WIDTH-bit operands by iterating one 4-bit Kogge-Stone slice over the operand, least significant nibble first, carrying the borrow chain between cycles. Operands enter and results leave through valid/ready handshakes, so the block can sit between a stimulus source and a result sink in the same test fabric as the adder.

## Interface
- `WIDTH`, default 16: operand width; multiple of 4, at least 4. N = WIDTH/4 slice cycles per operation.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands `a`/`b` are valid.
- `in_ready` output 1: block can accept operands. High only in IDLE.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: sink accepts the result.
- `diff` output WIDTH: `a - b` mod 2^WIDTH.
- `borrow_out` output 1: 1 when `a < b` unsigned.
- `overflow` output 1: signed overflow of `a - b`.

## Operation
- The FSM has three states.
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `a` and `~b`, set the carry register to 1, clear the slice counter, and go to RUN.
  - RUN: each cycle, slice k = counter runs `{c, d} = a[4k+3:4k] + ~b[4k+3:4k] + carry`. Store `d` into the working result at nibble k, update carry to `c`, and increment the counter. After slice N-1, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE. With `out_ready` low, hold indefinitely.
- The move from RUN to DONE loads `diff`, `borrow_out` and `overflow` as one registered update:
  - `borrow_out` = ~final carry.
  - `overflow` = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- `diff`, `borrow_out` and `overflow` hold their last completed result until the next completion. They never expose partial results.
- `in_valid` is ignored outside IDLE. Operand inputs are sampled only on the accepting edge.
- The slice counter is log2(N) bits wide, with a minimum of 1. It never wraps within an operation.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `diff`=0, `borrow_out`=0, `overflow`=0, counter=0, carry=0.
- Acceptance on edge T. Slices are processed on edges T+1 through T+N. `out_valid` goes high after edge T+N. Latency is N cycles; for WIDTH=16 that is 4.
- `in_ready` is a decode of state IDLE (combinational from the state register).
- Output handshake on edge U (`out_valid && out_ready`): `out_valid` drops and `in_ready` rises after U. The earliest next acceptance is edge U+1, so minimum throughput is one operation per N+2 cycles.
- `rst` asserted in any state (including mid-RUN or while DONE is stalled) aborts the operation immediately. All outputs take their reset values and no `out_valid` pulse is produced.
- `out_ready` high while not in DONE has no effect.

## Structure
- Package `ks_sub_pkg` holds:
  - `SLICE_W` = 4.
  - The FSM state typedef: IDLE, RUN, DONE.
  - A function computing signed overflow from the two operand MSBs and the result MSB.
- Sub-module `ks_sub_slice`: a combinational 4-bit Kogge-Stone prefix adder with carry-in. Its inputs are `x[3:0]`, `y[3:0]` and `cin`; its outputs are `s[3:0]` and `cout`. The top inverts `b` and feeds the slice.
- The top module contains the FSM, the operand/result nibble registers, the counter and the carry register.

## Test plan
All scenarios use WIDTH=16.
- Reset: assert `rst` for 3 cycles → `in_ready`=1, `out_valid`=0, `diff`=0x0000, `borrow_out`=0, `overflow`=0.
- Basic subtraction: a=0x1234, b=0x0234 → `out_valid` after exactly 4 cycles, `diff`=0x1000, `borrow_out`=0, `overflow`=0.
- Unsigned borrow: a=0x0000, b=0x0001 → `diff`=0xFFFF, `borrow_out`=1, `overflow`=0. Also a=0x1234, b=0x1234 → `diff`=0x0000, `borrow_out`=0.
- Signed overflow: a=0x8000, b=0x0001 → `diff`=0x7FFF, `borrow_out`=0, `overflow`=1.
- Backpressure: hold `out_ready`=0 for 10 cycles after completion and drive `in_valid` with a=0xFFFF, b=0x0001.
  - During the stall: result stays stable, `in_ready` stays 0, the new operands are ignored.
  - After `out_ready`: the next accepted pair computes correctly.
- Reset mid-operation: assert `rst` after 2 RUN cycles of a=0x5555, b=0x1111 → no `out_valid`. A following a=0x5555, b=0x1111 returns `diff`=0x4444.
